// File: rtl/stage_arb_pkg.sv
// Shared types and the round-robin pick helper for stage_rr_arbiter.
//   arb_state_t : FSM encoding (IDLE / GRANT)
//   rr_pick     : first set request at or above ptr, wrapping modulo num
package stage_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned RR_MAX_REQ = 16;
    localparam int unsigned RR_IDX_W   = 4;

    // Walks the request vector starting at ptr; the rotation offset k is
    // folded back into the real index so the result needs no unrotate step.
    // Returns ptr when nothing is requested (caller qualifies with "any").
    function automatic logic [RR_IDX_W-1:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] req,
        input logic [RR_IDX_W-1:0]   ptr,
        input int unsigned           num
    );
        logic [RR_IDX_W:0]   idx;
        logic [RR_IDX_W-1:0] win;
        logic                found;
        win   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
            idx = {1'b0, ptr} + (RR_IDX_W+1)'(k);
            if (idx >= (RR_IDX_W+1)'(num)) begin
                idx = idx - (RR_IDX_W+1)'(num);
            end
            if (!found && (k < num) && req[idx[RR_IDX_W-1:0]]) begin
                win   = idx[RR_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector.
//   req  : request vector, one bit per requester
//   ptr  : highest-priority index this round
//   pick : winning index (meaningful only when any=1)
//   any  : at least one request is set
module rr_priority_pick
    import stage_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GID_W-1:0]   ptr,
    output logic [GID_W-1:0]   pick,
    output logic               any
);

    logic [RR_MAX_REQ-1:0] req_ext;
    logic [RR_IDX_W-1:0]   ptr_ext;
    logic [RR_IDX_W-1:0]   win;

    assign req_ext = RR_MAX_REQ'(req);
    assign ptr_ext = RR_IDX_W'(ptr);
    assign win     = rr_pick(req_ext, ptr_ext, NUM_REQ);
    assign pick    = GID_W'(win);
    assign any     = |req;

endmodule

// File: rtl/stage_rr_arbiter.sv
// Round-robin arbiter feeding one registered DATA_W output stage from
// NUM_REQ burst sources over valid/ready.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/data/last   : per-requester beat offer (data slice i = [i*DATA_W +: DATA_W])
//   req_ready             : per-requester accept, only the grant holder can see 1
//   out_data/out_valid    : registered output beat
//   out_ready             : downstream accept
//   grant_id, busy        : current grant holder, grant active
//
// state | meaning
// IDLE  | no grant; choose next holder from rr_ptr upward
// GRANT | grant_id owns the stage until last beat or MAX_BURST beats
module stage_rr_arbiter
    import stage_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);

    localparam int GID_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t         state_q,     state_d;
    logic [GID_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [GID_W-1:0]   grant_id_q,  grant_id_d;
    logic [CNT_W-1:0]   beat_cnt_q,  beat_cnt_d;
    logic [DATA_W-1:0]  out_data_q,  out_data_d;
    logic               out_valid_q, out_valid_d;

    logic [GID_W-1:0]   pick;
    logic               pick_any;
    logic               out_free;
    logic               accept;
    logic [CNT_W-1:0]   beat_cnt_inc;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .GID_W   (GID_W)
    ) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr_q),
        .pick (pick),
        .any  (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        beat_cnt_d   = beat_cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        req_ready    = '0;
        accept       = 1'b0;
        out_free     = ~out_valid_q | out_ready;
        beat_cnt_inc = beat_cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = GRANT;
                    grant_id_d = pick;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                req_ready[grant_id_q] = out_free;
                accept = out_free & req_valid[grant_id_q];
                if (accept) begin
                    out_data_d  = req_data[grant_id_q*DATA_W +: DATA_W];
                    out_valid_d = 1'b1;
                    beat_cnt_d  = beat_cnt_inc;
                    if (req_last[grant_id_q] || (beat_cnt_inc == CNT_W'(MAX_BURST))) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_id_q == GID_W'(NUM_REQ - 1)) ? '0
                                                                       : grant_id_q + GID_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Drain can happen in either state; an accept in the same cycle wins.
        if (out_valid_q && out_ready && !accept) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            beat_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            beat_cnt_q  <= beat_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_stage_rr_arbiter.sv
// Directed and randomized bench for stage_rr_arbiter (NUM_REQ=4, MAX_BURST=4).
module tb_stage_rr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [1:0]                grant_id;
    logic                      busy;

    int checks = 0;
    int errors = 0;

    // Per-requester source queues: {last, data}
    logic [8:0] src_q [NUM_REQ][$];
    bit         rnd_en  = 0;
    bit         feed_en = 0;

    logic [5:0] push_seq [NUM_REQ];
    logic [5:0] exp_seq  [NUM_REQ];
    int         skip     [NUM_REQ];
    int         max_skip = 0;
    int         tot_push = 0;
    int         tot_out  = 0;
    logic [1:0] model_ptr = '0;
    int         mb_cnt = 0;

    // Values seen just before each active edge
    logic [3:0] s_acc, s_rv, s_last;
    logic       s_ofire, s_busy, s_rst;
    logic [1:0] s_gid;
    logic [7:0] s_od;

    stage_rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input int id, input logic [7:0] d, input logic l);
        src_q[id].push_back({l, d});
    endtask

    task automatic flush();
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    endtask

    // A presented beat is held until accepted; otherwise present the queue head.
    task automatic drive_inputs(input logic [3:0] acc);
        logic [8:0] b;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !acc[i] && src_q[i].size() > 0) begin
                req_valid[i] = 1'b1;
            end else if (src_q[i].size() > 0 && (!rnd_en || $urandom_range(0, 2) != 0)) begin
                b = src_q[i][0];
                req_valid[i] = 1'b1;
                req_data[i*DATA_W +: DATA_W] = b[7:0];
                req_last[i] = b[8];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic feed();
        int len;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() < 4) begin
                len = $urandom_range(1, 6);
                for (int b = 0; b < len; b++) begin
                    push(i, {2'(i), push_seq[i]}, (b == len - 1));
                    push_seq[i] = push_seq[i] + 6'd1;
                    tot_push++;
                end
            end
        end
    endtask

    task automatic score();
        logic [1:0] exp_g, idx;
        logic [1:0] src;
        bit         found;
        bit         rel;
        if (s_ofire) begin
            tot_out++;
            src = s_od[7:6];
            chk("order", 32'(s_od[5:0]), 32'(exp_seq[src]));
            exp_seq[src] = exp_seq[src] + 6'd1;
        end
        if (!s_busy) begin
            if (|s_acc) chk("idle_acc", 32'(s_acc), 32'd0);
            if (|s_rv) begin
                found = 0;
                exp_g = '0;
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = model_ptr + 2'(k);
                    if (!found && s_rv[idx]) begin
                        exp_g = idx;
                        found = 1;
                    end
                end
                chk("rr_grant", 32'({busy, grant_id}), 32'({1'b1, exp_g}));
                mb_cnt = 0;
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (j == int'(exp_g)) skip[j] = 0;
                    else if (s_rv[j]) skip[j]++;
                    if (skip[j] > max_skip) max_skip = skip[j];
                end
            end
        end else if (|s_acc) begin
            chk("acc_owner", 32'(s_acc), 32'(4'b0001 << s_gid));
            mb_cnt++;
            rel = s_last[s_gid] || (mb_cnt == MAX_BURST);
            chk("release", 32'(busy), 32'(!rel));
            if (rel) model_ptr = s_gid + 2'd1;
        end
    endtask

    // Requester/downstream driver
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            s_acc   = req_valid & req_ready;
            s_rv    = req_valid;
            s_last  = req_last;
            s_ofire = out_valid & out_ready;
            s_busy  = busy;
            s_gid   = grant_id;
            s_od    = out_data;
            s_rst   = reset;
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (s_acc[i]) void'(src_q[i].pop_front());
            end
            if (rnd_en && !s_rst) score();
            if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
            if (feed_en) feed();
            drive_inputs(s_acc);
        end
    end

    initial begin
        int n;
        bit pend;
        reset     = 1'b1;
        out_ready = 1'b0;
        cyc(2);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_grant_id",  32'(grant_id),  32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);

        // Single requester 2, three beats
        reset     = 1'b0;
        out_ready = 1'b1;
        push(2, 8'h11, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h33, 1'b1);
        drive_inputs('0);
        #1;
        chk("t2_idle_busy",  32'(busy),      32'd0);
        chk("t2_idle_ready", 32'(req_ready), 32'd0);
        cyc(1);
        chk("t2_c1_busy",  32'(busy),      32'd1);
        chk("t2_c1_gid",   32'(grant_id),  32'd2);
        chk("t2_c1_ready", 32'(req_ready), 32'h4);
        chk("t2_c1_oval",  32'(out_valid), 32'd0);
        cyc(1);
        chk("t2_c2_data",  32'({out_valid, out_data}), 32'h111);
        cyc(1);
        chk("t2_c3_data",  32'({out_valid, out_data}), 32'h122);
        chk("t2_c3_busy",  32'(busy), 32'd1);
        cyc(1);
        chk("t2_c4_data",  32'({out_valid, out_data}), 32'h133);
        chk("t2_c4_busy",  32'(busy), 32'd0);
        chk("t2_c4_gid",   32'(grant_id), 32'd2);
        chk("t2_c4_ready", 32'(req_ready), 32'd0);
        cyc(1);
        chk("t2_c5_oval",  32'(out_valid), 32'd0);

        // Reset mid-burst with a stalled beat in the output register
        out_ready = 1'b0;
        push(3, 8'h31, 1'b0);
        push(3, 8'h32, 1'b0);
        push(3, 8'h33, 1'b1);
        drive_inputs('0);
        #1;
        cyc(1);
        chk("t1_gid",   32'(grant_id),  32'd3);
        chk("t1_ready", 32'(req_ready), 32'h8);
        cyc(1);
        chk("t1_held",  32'({busy, out_valid, out_data}), 32'h331);
        reset = 1'b1;
        flush();
        drive_inputs('0);
        cyc(1);
        chk("t1_rst_oval",  32'(out_valid), 32'd0);
        chk("t1_rst_busy",  32'(busy),      32'd0);
        chk("t1_rst_ready", 32'(req_ready), 32'd0);
        chk("t1_rst_data",  32'(out_data),  32'd0);

        // Requesters 0,1,3 with single-beat bursts; rr_ptr must restart at 0
        reset     = 1'b0;
        out_ready = 1'b1;
        push(0, 8'hA0, 1'b1);
        push(0, 8'hA1, 1'b1);
        push(1, 8'hB0, 1'b1);
        push(3, 8'hD0, 1'b1);
        drive_inputs('0);
        #1;
        cyc(1);
        chk("t3_g0", 32'({busy, grant_id}), 32'h4);
        cyc(1);
        chk("t3_bubble0", 32'(busy), 32'd0);
        chk("t3_d0", 32'(out_data), 32'hA0);
        cyc(1);
        chk("t3_g1", 32'({busy, grant_id}), 32'h5);
        cyc(1);
        chk("t3_bubble1", 32'(busy), 32'd0);
        chk("t3_d1", 32'(out_data), 32'hB0);
        cyc(1);
        chk("t3_g3", 32'({busy, grant_id}), 32'h7);
        cyc(1);
        chk("t3_bubble3", 32'(busy), 32'd0);
        chk("t3_d3", 32'(out_data), 32'hD0);
        cyc(1);
        chk("t3_g0b", 32'({busy, grant_id}), 32'h4);
        cyc(1);
        chk("t3_d0b", 32'({busy, out_data}), 32'h0A1);

        // Requester 1: 6 beats without last, forced release at MAX_BURST
        for (int i = 0; i < 6; i++) push(1, 8'h40 + 8'(i), 1'b0);
        push(3, 8'h70, 1'b0);
        push(3, 8'h71, 1'b1);
        drive_inputs('0);
        #1;
        cyc(1);
        chk("t4_g1", 32'({busy, grant_id}), 32'h5);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("t4_burst_data", 32'(out_data), 32'h40 + 32'(i));
        end
        chk("t4_forced_rel", 32'(busy), 32'd0);
        cyc(1);
        chk("t4_g3", 32'({busy, grant_id}), 32'h7);
        cyc(1);
        chk("t4_d70", 32'(out_data), 32'h70);
        cyc(1);
        chk("t4_d71", 32'({busy, out_data}), 32'h071);
        cyc(1);
        chk("t4_g1b", 32'({busy, grant_id}), 32'h5);
        cyc(1);
        chk("t4_d44", 32'(out_data), 32'h44);
        cyc(1);
        chk("t4_d45_held_grant", 32'({busy, out_valid, out_data}), 32'h345);

        // Downstream stall for 5 cycles inside the held grant
        out_ready = 1'b0;
        push(1, 8'h60, 1'b0);
        push(1, 8'h61, 1'b1);
        drive_inputs('0);
        #1;
        chk("t5_stall_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("t5_stall_data",  32'({out_valid, out_data}), 32'h145);
            chk("t5_stall_ready", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("t5_resume_ready", 32'(req_ready), 32'h2);
        cyc(1);
        chk("t5_d60", 32'({out_valid, out_data}), 32'h160);
        cyc(1);
        chk("t5_d61", 32'({busy, out_valid, out_data}), 32'h161);
        cyc(1);
        chk("t5_drained", 32'(out_valid), 32'd0);

        // Randomized traffic with scoreboard and round-robin model
        reset = 1'b1;
        flush();
        drive_inputs('0);
        cyc(1);
        for (int i = 0; i < NUM_REQ; i++) begin
            push_seq[i] = '0;
            exp_seq[i]  = '0;
            skip[i]     = 0;
        end
        model_ptr = '0;
        mb_cnt    = 0;
        reset     = 1'b0;
        rnd_en    = 1;
        feed_en   = 1;
        repeat (10000) @(posedge clk);
        feed_en = 0;
        n = 0;
        pend = 1;
        while (pend && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
            pend = out_valid || busy;
            for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() > 0) pend = 1;
        end
        chk("drain_timeout", 32'(pend), 32'd0);
        chk("beat_count", 32'(tot_out), 32'(tot_push));
        chk("starvation", 32'(max_skip <= NUM_REQ - 1), 32'd1);
        rnd_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
